reg8_serial_tx: RTL

Parallel-to-serial transmitter. It takes an 8-bit word from a register output, such as the memory unit's enabled register bank, and shifts it out on a single line.
- Frame format: one start bit (0), 8 data bits LSB first, one stop bit (1).
- Upstream interface: valid/ready handshake.
- Sits between the register/memory unit and an off-block serial link. It is the reading/emitting end of the register write path.

---
 rtl/reg8_serial_tx_if.sv | 35 +++
 rtl/reg8_serial_tx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/reg8_serial_tx_if.sv
// -----------------------------------------------------------------------------
// reg8_serial_tx_if
// Purpose : groups the upstream valid/ready word handshake and the serial-side
//           status/line signals of reg8_serial_tx into one bundle.
// Signals :
//   Tx_Data  [DATA_W] word offered by the upstream register bank
//   Tx_Valid          upstream has a word on Tx_Data
//   Tx_Ready          transmitter can take a word this cycle (IDLE only)
//   Tx_Out            serial line, idles high
//   Tx_Busy           frame in progress
//   Tx_Done           one-cycle pulse in the last clk of the stop bit
// Modports:
//   master - upstream/observer side (drives Tx_Data, Tx_Valid)
//   slave  - transmitter side (drives Tx_Ready, Tx_Out, Tx_Busy, Tx_Done)
// -----------------------------------------------------------------------------
interface reg8_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] Tx_Data;
  logic              Tx_Valid;
  logic              Tx_Ready;
  logic              Tx_Out;
  logic              Tx_Busy;
  logic              Tx_Done;

  modport master (
    output Tx_Data, Tx_Valid,
    input  Tx_Ready, Tx_Out, Tx_Busy, Tx_Done
  );

  modport slave (
    input  Tx_Data, Tx_Valid,
    output Tx_Ready, Tx_Out, Tx_Busy, Tx_Done
  );
endinterface

// File: rtl/reg8_serial_tx.sv
// -----------------------------------------------------------------------------
// reg8_serial_tx
// Purpose : parallel-to-serial transmitter. A word accepted over a valid/ready
//           handshake is sent as: start bit (0), DATA_W data bits LSB first,
//           optional even-parity bit, stop bit (1). Each bit is held for
//           CLKS_PER_BIT clk cycles.
// Ports   :
//   clk  - system clock, rising edge
//   res  - asynchronous active-low reset
//   tx   - reg8_serial_tx_if.slave bundle (Tx_Data, Tx_Valid in;
//          Tx_Ready, Tx_Out, Tx_Busy, Tx_Done out)
// Optional feature:
//   `define REG8_SERIAL_TX_PARITY_EN inserts a PARITY state between DATA and
//   STOP carrying the XOR of the latched word. Undefined (default): no parity.
// -----------------------------------------------------------------------------
module reg8_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input logic             clk,
  input logic             res,
  reg8_serial_tx_if.slave tx
);

  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [7:0]       BAUD_LAST = 8'(CLKS_PER_BIT - 1);
  // Baud value one cycle before the end of a bit; Tx_Done is loaded here so the
  // registered pulse lands in the final stop-bit cycle.
  localparam logic [7:0]       BAUD_NEAR = 8'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
  // With one clk per bit the stop bit is its own final cycle, so Tx_Done must
  // be raised on the edge that enters STOP.
  localparam logic             DONE_ON_ENTRY = (CLKS_PER_BIT == 1);

`ifdef REG8_SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [BIT_W-1:0]  bit_q;
  logic [7:0]        baud_q;
  logic              out_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
`ifdef REG8_SERIAL_TX_PARITY_EN
  logic              parity_q;
`endif

  // Word after the end-of-bit shift; its bit 0 is the next bit on the line.
  always_comb begin
    shift_d = shift_q >> 1;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      baud_q   <= '0;
      out_q    <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef REG8_SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx.Tx_Valid) begin
            shift_q  <= tx.Tx_Data;
            baud_q   <= '0;
            out_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= START;
`ifdef REG8_SERIAL_TX_PARITY_EN
            parity_q <= ^tx.Tx_Data;
`endif
          end
        end

        START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            bit_q   <= '0;
            out_q   <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 8'd1;
          end
        end

        DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            shift_q <= shift_d;
            if (bit_q == BIT_LAST) begin
`ifdef REG8_SERIAL_TX_PARITY_EN
              out_q   <= parity_q;
              state_q <= PARITY;
`else
              out_q   <= 1'b1;
              done_q  <= DONE_ON_ENTRY;
              state_q <= STOP;
`endif
            end else begin
              bit_q <= bit_q + BIT_W'(1);
              out_q <= shift_d[0];
            end
          end else begin
            baud_q <= baud_q + 8'd1;
          end
        end

`ifdef REG8_SERIAL_TX_PARITY_EN
        PARITY: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            out_q   <= 1'b1;
            done_q  <= DONE_ON_ENTRY;
            state_q <= STOP;
          end else begin
            baud_q <= baud_q + 8'd1;
          end
        end
`endif

        STOP: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + 8'd1;
            done_q <= (baud_q == BAUD_NEAR);
          end
        end

        default: begin
          state_q <= IDLE;
          out_q   <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx.Tx_Out   = out_q;
  assign tx.Tx_Ready = ready_q;
  assign tx.Tx_Busy  = busy_q;
  assign tx.Tx_Done  = done_q;

endmodule
